game_ctrl_ext: RTL and testbench
================================

# game_ctrl_ext

Parametrised game-flow controller for the Flappy-style game core; the next generation of the IDLE/PLAY/OVER controller. It sits between the key inputs, the collision/score detectors, and the physics, pipe and display blocks. Beyond start/play/over it adds multiple lives with a timed respawn window, pause, a configurable-width saturating BCD score, a persistent high score, and a level counter driven by score progress.

## Interface
Parameters:
- SCORE_DIGITS, 4, number of BCD digits in score and high score (1..8)
- LIVES, 3, lives loaded at game start (1..15)
- RESPAWN_CYCLES, 50_000_000, clk cycles spent in RESPAWN after a non-final collision (>=1)
- PAUSE_EN, 1, 1 = pause key honoured, 0 = pause key ignored
- LEVEL_STEP, 10, score points per level increment (>=1)
- LEVEL_W, 3, level counter width

Ports (single clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- key_jump  in  1  jump/start key, high = pressed, already debounced
- key_pause  in  1  pause key, high = pressed, already debounced
- collision  in  1  level-sensitive collision flag
- score_pulse  in  1  one-cycle pulse per pipe passed
- game_active  out  1  high only in PLAY; enables physics and pipe scroll
- state  out  3  0=IDLE, 1=PLAY, 2=OVER, 3=PAUSE, 4=RESPAWN
- score_bcd  out  4*SCORE_DIGITS  current score, digit 0 in [3:0]
- hiscore_bcd  out  4*SCORE_DIGITS  best score since reset
- lives  out  4  remaining lives
- level  out  LEVEL_W  current level, 0 at start
- level_up  out  1  one-cycle pulse when level increments
- new_record  out  1  high in OVER when the game just ended beat hiscore

## Operation
- Edge detect: each key goes through two registers (d0, d1); rise = d0 & ~d1. All state decisions use rise, never level.
- IDLE: score=0, level=0, lives=LIVES, level counter cleared, new_record=0. jump rise -> PLAY.
- PLAY: score_pulse adds 1 to score (BCD, per-digit carry). At all-9s, score saturates with no wrap. Each LEVEL_STEP accepted pulses increments level and pulses level_up; level saturates at 2^LEVEL_W-1 with no level_up at saturation. An accepted pulse at saturated score still counts toward level.
- PLAY + collision: lives decrements. If the result is 0 -> OVER, else -> RESPAWN. Collision has priority over a same-cycle pause rise. A same-cycle score_pulse is still counted.
- PLAY + pause rise (PAUSE_EN=1, no collision) -> PAUSE.
- PAUSE: score_pulse and collision ignored. Pause rise -> PLAY. Jump rise ignored.
- RESPAWN: counter runs RESPAWN_CYCLES cycles, then -> PLAY. Collision, score_pulse and keys ignored.
- OVER: on entry, if score > hiscore (unsigned compare of packed BCD), hiscore <= score and new_record=1. Jump rise -> IDLE; new_record clears on leaving OVER.
- hiscore_bcd is cleared only by rst.
- Undefined state encodings -> IDLE next cycle.

## Timing
- Reset (rst high at an edge): state=IDLE, game_active=0, score=0, hiscore=0, lives=LIVES, level=0, level_up=0, new_record=0, key regs=0, respawn counter=0.
- Key latency: key high before edge k -> rise valid in cycle after k -> state changes at edge k+1.
- state, game_active, lives, score, level are registered and update at the same edge as the causing transition or pulse. game_active tracks state==PLAY with no extra delay.
- Collision sampled at edge e in PLAY: lives and state update at e.
- RESPAWN: entered at edge e; PLAY at edge e+RESPAWN_CYCLES.
- hiscore and new_record update on the same edge that enters OVER.
- level_up is high for exactly one cycle, aligned with the level change.
- rst mid-game: the full reset state applies at the next edge regardless of state; this is the only way hiscore returns to 0.

## Test plan
- Reset then jump held high 5 cycles: one PLAY entry only; state=1 two edges after key high; game_active=1; lives=3.
- 12 score_pulses in PLAY (LEVEL_STEP=10): score_bcd=0x0012, level=1, exactly one level_up pulse.
- SCORE_DIGITS=2, 105 pulses: score saturates at 0x99 and never wraps.
- Collision ×3 with RESPAWN_CYCLES=4: lives 3->2->1->0. After each of the first two, RESPAWN lasts 4 cycles with game_active=0 and score_pulse ignored. The third goes to OVER.
- Game 1 scores 7, game 2 scores 5, game 3 scores 9: hiscore_bcd =7, 7, 9; new_record =1, 0, 1 in OVER. After OVER->IDLE, score=0 while hiscore is retained.
- Pause rise and collision in the same cycle: OVER or RESPAWN, not PAUSE. With PAUSE_EN=0, pause rise has no effect. A pulse during PAUSE leaves the score unchanged.

Source files
------------

// File: rtl/game_ctrl_ext.sv
// game_ctrl_ext: Flappy-style game-flow controller with lives, respawn, pause, BCD score, hiscore and levels
// Inputs:  clk, rst (sync, active-high), key_jump, key_pause (debounced keys), collision (level), score_pulse (1-cycle)
// Outputs: game_active (PLAY only), state (0 IDLE,1 PLAY,2 OVER,3 PAUSE,4 RESPAWN), score_bcd, hiscore_bcd,
//          lives, level, level_up (1-cycle), new_record (in OVER)
module game_ctrl_ext #(
  parameter int SCORE_DIGITS   = 4,
  parameter int LIVES          = 3,
  parameter int RESPAWN_CYCLES = 50_000_000,
  parameter int PAUSE_EN       = 1,
  parameter int LEVEL_STEP     = 10,
  parameter int LEVEL_W        = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_jump,
  input  logic                      key_pause,
  input  logic                      collision,
  input  logic                      score_pulse,
  output logic                      game_active,
  output logic [2:0]                state,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [4*SCORE_DIGITS-1:0] hiscore_bcd,
  output logic [3:0]                lives,
  output logic [LEVEL_W-1:0]        level,
  output logic                      level_up,
  output logic                      new_record
);
  localparam int SW  = 4 * SCORE_DIGITS;
  localparam int RW  = $clog2(RESPAWN_CYCLES + 1);
  localparam int LSW = $clog2(LEVEL_STEP + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, OVER = 3'd2, PAUSE = 3'd3, RESPAWN = 3'd4} state_e;
  state_e state_q, state_d;
  logic [SW-1:0] score_q, score_d, hi_q, hi_d;
  logic [3:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LSW-1:0] lcnt_q, lcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic lup_q, lup_d, rec_q, rec_d, ga_q;
  logic j0_q, j1_q, p0_q, p1_q;
  logic jump_rise, pause_rise, accept, lvl_wrap;
  assign jump_rise  = j0_q & ~j1_q;
  assign pause_rise = p0_q & ~p1_q & (PAUSE_EN != 0);
  assign accept     = (state_q == PLAY) & score_pulse;
  assign lvl_wrap   = lcnt_q == LSW'(LEVEL_STEP - 1);
  // Per-digit BCD increment; an all-9s value has a carry out of the top digit and is held.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic c;
    c = 1'b1;
    bcd_inc = v;
    for (int i = 0; i < SCORE_DIGITS; i++)
      if (c) begin
        bcd_inc[4*i+:4] = (v[4*i+:4] == 4'd9) ? 4'd0 : v[4*i+:4] + 4'd1;
        c = v[4*i+:4] == 4'd9;
      end
    if (c) bcd_inc = v;
  endfunction
  always_comb begin
    state_d = state_q;
    score_d = accept ? bcd_inc(score_q) : score_q;
    hi_d    = hi_q;
    lives_d = lives_q;
    lcnt_d  = accept ? (lvl_wrap ? '0 : lcnt_q + LSW'(1)) : lcnt_q;
    lup_d   = accept & lvl_wrap & (level_q != '1);
    level_d = lup_d ? level_q + LEVEL_W'(1) : level_q;
    rcnt_d  = rcnt_q;
    rec_d   = rec_q;
    case (state_q)
      IDLE:  state_d = jump_rise ? PLAY : IDLE;
      PLAY:
        if (collision) begin
          lives_d = lives_q - 4'd1;
          state_d = (lives_q == 4'd1) ? OVER : RESPAWN;
          rcnt_d  = '0;
        end else if (pause_rise) state_d = PAUSE;
      PAUSE: state_d = pause_rise ? PLAY : PAUSE;
      RESPAWN: begin
        rcnt_d  = rcnt_q + RW'(1);
        state_d = (rcnt_q == RW'(RESPAWN_CYCLES - 1)) ? PLAY : RESPAWN;
      end
      OVER:    state_d = jump_rise ? IDLE : OVER;
      default: state_d = IDLE;
    endcase
    // The score entering OVER already includes a pulse accepted on the colliding cycle.
    if (state_d == OVER && state_q != OVER && score_d > hi_q) begin
      hi_d  = score_d;
      rec_d = 1'b1;
    end
    if (state_d == IDLE) begin
      score_d = '0;
      level_d = '0;
      lcnt_d  = '0;
      lives_d = 4'(LIVES);
      rec_d   = 1'b0;
      lup_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      score_q <= '0;
      hi_q    <= '0;
      lives_q <= 4'(LIVES);
      level_q <= '0;
      lcnt_q  <= '0;
      rcnt_q  <= '0;
      lup_q   <= 1'b0;
      rec_q   <= 1'b0;
      ga_q    <= 1'b0;
      {j0_q, j1_q, p0_q, p1_q} <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      hi_q    <= hi_d;
      lives_q <= lives_d;
      level_q <= level_d;
      lcnt_q  <= lcnt_d;
      rcnt_q  <= rcnt_d;
      lup_q   <= lup_d;
      rec_q   <= rec_d;
      ga_q    <= state_d == PLAY;
      {j0_q, j1_q, p0_q, p1_q} <= {key_jump, j0_q, key_pause, p0_q};
    end
  end
  assign game_active = ga_q;
  assign state       = state_q;
  assign score_bcd   = score_q;
  assign hiscore_bcd = hi_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign level_up    = lup_q;
  assign new_record  = rec_q;
endmodule

// File: tb/tb_game_ctrl_ext.sv
// tb_game_ctrl_ext: directed stimulus on two controllers (pause enabled/disabled) against a behavioural model
module tb_game_ctrl_ext;
  localparam int SD = 2, NL = 3, RESP = 4, LSTEP = 10, LW = 3;
  localparam int MAXS = 99, LMAX = 7;
  logic clk = 0, rst = 1, key_jump = 0, key_pause = 0, collision = 0, score_pulse = 0;
  logic ga [2];
  logic [2:0] st [2];
  logic [4*SD-1:0] sc [2];
  logic [4*SD-1:0] hs [2];
  logic [3:0] lv [2];
  logic [LW-1:0] lvl [2];
  logic lu [2];
  logic nr [2];
  int checks = 0, errors = 0, lu_cnt = 0, base;
  bit armed = 0;
  typedef struct {
    int st, score, hi, lives, pulses, level, rem;
    bit lup, rec, ga, j0, j1, p0, p1;
  } m_t;
  m_t m [2];
  always #5 clk = ~clk;
  game_ctrl_ext #(.SCORE_DIGITS(SD), .LIVES(NL), .RESPAWN_CYCLES(RESP), .PAUSE_EN(1), .LEVEL_STEP(LSTEP), .LEVEL_W(LW)) dut0 (
    .clk(clk), .rst(rst), .key_jump(key_jump), .key_pause(key_pause), .collision(collision), .score_pulse(score_pulse),
    .game_active(ga[0]), .state(st[0]), .score_bcd(sc[0]), .hiscore_bcd(hs[0]), .lives(lv[0]), .level(lvl[0]),
    .level_up(lu[0]), .new_record(nr[0]));
  game_ctrl_ext #(.SCORE_DIGITS(SD), .LIVES(NL), .RESPAWN_CYCLES(RESP), .PAUSE_EN(0), .LEVEL_STEP(LSTEP), .LEVEL_W(LW)) dut1 (
    .clk(clk), .rst(rst), .key_jump(key_jump), .key_pause(key_pause), .collision(collision), .score_pulse(score_pulse),
    .game_active(ga[1]), .state(st[1]), .score_bcd(sc[1]), .hiscore_bcd(hs[1]), .lives(lv[1]), .level(lvl[1]),
    .level_up(lu[1]), .new_record(nr[1]));
  function automatic m_t mreset();
    m_t r;
    r = '{default: 0};
    r.lives = NL;
    return r;
  endfunction
  function automatic logic [4*SD-1:0] to_bcd(input int v);
    logic [4*SD-1:0] r;
    for (int i = 0; i < SD; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic m_t step(input m_t o, input bit pe, input bit kj, input bit kp, input bit col, input bit sp);
    m_t n;
    bit jr, pr;
    int nl;
    n = o;
    jr = o.j0 & !o.j1;
    pr = o.p0 & !o.p1;
    n.j0 = kj; n.j1 = o.j0; n.p0 = kp; n.p1 = o.p0; n.lup = 0;
    if (o.st == 1 && sp) begin
      n.score = (o.score < MAXS) ? o.score + 1 : MAXS;
      n.pulses = o.pulses + 1;
      nl = n.pulses / LSTEP;
      if (nl > LMAX) nl = LMAX;
      if (nl != o.level) begin n.level = nl; n.lup = 1; end
    end
    case (o.st)
      0: if (jr) n.st = 1;
      1: if (col) begin
           n.lives = o.lives - 1;
           n.st = (n.lives == 0) ? 2 : 4;
           n.rem = RESP;
         end else if (pr && pe) n.st = 3;
      3: if (pr) n.st = 1;
      4: begin n.rem = o.rem - 1; if (n.rem == 0) n.st = 1; end
      2: if (jr) n.st = 0;
      default: n.st = 0;
    endcase
    if (n.st == 2 && o.st != 2 && n.score > o.hi) begin n.hi = n.score; n.rec = 1; end
    if (n.st == 0) begin n.score = 0; n.pulses = 0; n.level = 0; n.lives = NL; n.rec = 0; end
    n.ga = n.st == 1;
    return n;
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      m[i] = rst ? mreset() : step(m[i], i == 0, key_jump, key_pause, collision, score_pulse);
    if (rst) armed = 1;
  end
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("d%0d state", i), 32'(st[i]), 32'(m[i].st));
        chk($sformatf("d%0d game_active", i), 32'(ga[i]), 32'(m[i].ga));
        chk($sformatf("d%0d score", i), 32'(sc[i]), 32'(to_bcd(m[i].score)));
        chk($sformatf("d%0d hiscore", i), 32'(hs[i]), 32'(to_bcd(m[i].hi)));
        chk($sformatf("d%0d lives", i), 32'(lv[i]), 32'(m[i].lives));
        chk($sformatf("d%0d level", i), 32'(lvl[i]), 32'(m[i].level));
        chk($sformatf("d%0d level_up", i), 32'(lu[i]), 32'(m[i].lup));
        chk($sformatf("d%0d new_record", i), 32'(nr[i]), 32'(m[i].rec));
      end
      if (lu[0]) lu_cnt++;
    end
  end
  task automatic cyc(input bit kj, input bit kp, input bit col, input bit sp);
    key_jump = kj; key_pause = kp; collision = col; score_pulse = sp;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask
  task automatic pulses(input int n);
    repeat (n) begin cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); end
  endtask
  task automatic start_game();
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
  endtask
  task automatic end_game();
    repeat (3) begin cyc(0, 0, 1, 0); idle(RESP); end
  endtask
  initial begin
    idle(2);
    rst = 0;
    chk("rst state", 32'(st[0]), 0);
    chk("rst lives", 32'(lv[0]), 3);
    chk("rst score", 32'(sc[0]), 0);
    chk("rst hiscore", 32'(hs[0]), 0);
    cyc(1, 0, 0, 0);
    chk("jump edge1 state", 32'(st[0]), 0);
    cyc(1, 0, 0, 0);
    chk("jump edge2 state", 32'(st[0]), 1);
    chk("jump game_active", 32'(ga[0]), 1);
    chk("jump lives", 32'(lv[0]), 3);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("held jump state", 32'(st[0]), 1);
    pulses(7);
    chk("g1 score", 32'(sc[0]), 32'h07);
    cyc(0, 0, 1, 0);
    chk("col1 state", 32'(st[0]), 4);
    chk("col1 lives", 32'(lv[0]), 2);
    chk("col1 game_active", 32'(ga[0]), 0);
    cyc(0, 0, 0, 1);
    chk("resp1 state", 32'(st[0]), 4);
    idle(2);
    chk("resp3 state", 32'(st[0]), 4);
    idle(1);
    chk("resp end state", 32'(st[0]), 1);
    chk("resp pulse ignored", 32'(sc[0]), 32'h07);
    cyc(0, 0, 1, 0);
    chk("col2 lives", 32'(lv[0]), 1);
    idle(RESP);
    chk("col2 back to play", 32'(st[0]), 1);
    cyc(0, 0, 1, 0);
    chk("col3 state", 32'(st[0]), 2);
    chk("col3 lives", 32'(lv[0]), 0);
    chk("g1 hiscore", 32'(hs[0]), 32'h07);
    chk("g1 new_record", 32'(nr[0]), 1);
    idle(2);
    start_game();
    chk("to idle state", 32'(st[0]), 0);
    chk("idle score", 32'(sc[0]), 0);
    chk("idle hiscore", 32'(hs[0]), 32'h07);
    chk("idle new_record", 32'(nr[0]), 0);
    chk("idle lives", 32'(lv[0]), 3);
    start_game(); pulses(5); end_game();
    chk("g2 state", 32'(st[0]), 2);
    chk("g2 hiscore", 32'(hs[0]), 32'h07);
    chk("g2 new_record", 32'(nr[0]), 0);
    start_game();
    start_game(); pulses(9); end_game();
    chk("g3 hiscore", 32'(hs[0]), 32'h09);
    chk("g3 new_record", 32'(nr[0]), 1);
    start_game();
    start_game();
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    chk("pause state", 32'(st[0]), 3);
    chk("pause disabled state", 32'(st[1]), 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 1, 0);
    chk("pause score", 32'(sc[0]), 0);
    chk("pause lives", 32'(lv[0]), 3);
    chk("pause held", 32'(st[0]), 3);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    chk("unpause state", 32'(st[0]), 1);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
    chk("col+pause state", 32'(st[0]), 4);
    chk("col+pause lives", 32'(lv[0]), 2);
    idle(RESP);
    base = lu_cnt;
    pulses(12);
    chk("12 score", 32'(sc[0]), 32'h12);
    chk("12 level", 32'(lvl[0]), 1);
    chk("12 level_up count", 32'(lu_cnt - base), 1);
    pulses(93);
    chk("sat score", 32'(sc[0]), 32'h99);
    chk("sat level", 32'(lvl[0]), 7);
    chk("sat level_up count", 32'(lu_cnt - base), 7);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
